lcd_nibble_writer: RTL and testbench

Parametrised 4-bit character-LCD write engine (HD44780-compatible) driving the `oLCD_*` pins of the MiniAlu top level. It accepts byte transfers (command or data) through a valid/ready handshake and splits each into two enable-strobed nibbles. It applies configurable setup, enable, hold, inter-nibble and post-command delays. Optionally it runs the power-up initialisation sequence on its own before accepting traffic.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_delay_counter.sv | 25 ++
 rtl/lcd_nibble_writer.sv | 243 ++++++++++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the 4-bit character-LCD write engine.
//   - lcd_state_e     : FSM state encoding
//   - LCD_CMD_CLEAR/HOME : commands that need the long post-command wait
//   - init_nibble / init_wait_base : power-up init table (nibble, unscaled wait)
//   - is_long_cmd     : selects the long wait for clear/home style commands
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_INIT_NIB = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_PULSE    = 3'd4,
        ST_HOLD     = 3'd5,
        ST_GAP      = 3'd6,
        ST_WAIT     = 3'd7
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Init sequence: 3, 3, 3, 2 (switch the controller into 4-bit mode).
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Waits are expressed for CMD_WAIT_CYCLES = 2000 and scaled by the top.
    function automatic int unsigned init_wait_base(input logic [1:0] idx);
        case (idx)
            2'd0:    return 205000;
            2'd1:    return 5000;
            default: return 2000;
        endcase
    endfunction

    // 0x03 also decodes as return-home on HD44780, so it gets the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == LCD_CMD_CLEAR || b == LCD_CMD_HOME || b == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: loadable down-counter timing every FSM state.
//   i_clk, i_rst : clock, async active-high reset (counter <- RST_VAL)
//   i_load       : load i_value this cycle (else count down, saturating at 0)
//   i_value      : N-1 for a state lasting N cycles
//   o_zero       : counter is 0, the current state ends this cycle
module lcd_delay_counter #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)              r_cnt <= RST_VAL;
        else if (i_load)        r_cnt <= i_value;
        else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: HD44780 4-bit write engine. Takes a byte (command or
// data) over valid/ready and emits it as two E-strobed nibbles, high first,
// with setup/enable/hold, inter-nibble and post-command delays.
// Optional feature macro: LCD_INIT_SEQ_EN -- when defined, the engine waits
// POWERUP_CYCLES after reset and sends the 3,3,3,2 init nibbles by itself.
// Ports:
//   Clock, Reset            : clock, async active-high reset
//   iValid, iRS, iData      : byte offer (iRS 0 = command, 1 = data)
//   oReady, oBusy           : accept strobe (IDLE only) and its inverse
//   oLCD_Enabled            : E
//   oLCD_RegisterSelect     : RS
//   oLCD_Data               : DB7..DB4
//   oLCD_StrataFlashControl : constant 1 (shared flash held off)
//   oLCD_ReadWrite          : constant 0 (write-only)
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES      = 2,
    parameter int ENABLE_CYCLES     = 12,
    parameter int HOLD_CYCLES       = 1,
    parameter int NIBBLE_GAP_CYCLES = 50,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int LONG_WAIT_CYCLES  = 82000,
    parameter int POWERUP_CYCLES    = 750000,
    parameter int CNT_W             = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iValid,
    input  logic       iRS,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oBusy,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);
    localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_ENABLE = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(NIBBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_CMD    = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_LONG   = CNT_W'(LONG_WAIT_CYCLES - 1);
    // Counter comes out of reset timing the power-up wait; without the init
    // sequence the engine sits in IDLE, which never looks at the counter.
    localparam logic [CNT_W-1:0] L_PWR    = CNT_W'(POWERUP_CYCLES - 1);

`ifdef LCD_INIT_SEQ_EN
    localparam lcd_state_e ST_RESET = ST_PWR_WAIT;
    localparam logic       RDY_RST  = 1'b0;
`else
    localparam lcd_state_e ST_RESET = ST_IDLE;
    localparam logic       RDY_RST  = 1'b1;
`endif

    lcd_state_e       r_state, w_state_nx;
    logic [7:0]       r_byte, w_byte_nx;
    logic             r_rs, w_rs_nx;
    logic             r_lower, w_lower_nx;   // 1 while the low nibble is out
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_zero;

    logic             r_e, r_rs_o, r_ready, r_busy;
    logic [3:0]       r_data;
    logic             w_e_nx, w_rs_o_nx, w_ready_nx;
    logic [3:0]       w_data_nx;

`ifdef LCD_INIT_SEQ_EN
    logic             r_init, w_init_nx;     // current nibble belongs to init
    logic [1:0]       r_idx, w_idx_nx;
    logic [CNT_W-1:0] w_init_wait;

    always_comb begin
        case (r_idx)
            2'd0:    w_init_wait = CNT_W'(int'(init_wait_base(2'd0)) * CMD_WAIT_CYCLES / 2000 - 1);
            2'd1:    w_init_wait = CNT_W'(int'(init_wait_base(2'd1)) * CMD_WAIT_CYCLES / 2000 - 1);
            default: w_init_wait = CNT_W'(int'(init_wait_base(2'd2)) * CMD_WAIT_CYCLES / 2000 - 1);
        endcase
    end
`endif

    lcd_delay_counter #(.CNT_W(CNT_W), .RST_VAL(L_PWR)) u_cnt (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_zero)
    );

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_RESET;
            r_byte  <= '0;
            r_rs    <= 1'b0;
            r_lower <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            r_init  <= 1'b1;
            r_idx   <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_byte  <= w_byte_nx;
            r_rs    <= w_rs_nx;
            r_lower <= w_lower_nx;
`ifdef LCD_INIT_SEQ_EN
            r_init  <= w_init_nx;
            r_idx   <= w_idx_nx;
`endif
        end
    end

    // Next state; every transition reloads the counter with the new state's N-1
    always_comb begin
        w_state_nx = r_state;
        w_byte_nx  = r_byte;
        w_rs_nx    = r_rs;
        w_lower_nx = r_lower;
        w_load     = 1'b0;
        w_load_val = L_SETUP;
`ifdef LCD_INIT_SEQ_EN
        w_init_nx  = r_init;
        w_idx_nx   = r_idx;
`endif
        case (r_state)
            ST_IDLE: if (iValid) begin
                w_state_nx = ST_SETUP;
                w_byte_nx  = iData;
                w_rs_nx    = iRS;
                w_lower_nx = 1'b0;
                w_load     = 1'b1;
                w_load_val = L_SETUP;
            end
            ST_SETUP: if (w_zero) begin
                w_state_nx = ST_PULSE;
                w_load     = 1'b1;
                w_load_val = L_ENABLE;
            end
            ST_PULSE: if (w_zero) begin
                w_state_nx = ST_HOLD;
                w_load     = 1'b1;
                w_load_val = L_HOLD;
            end
            ST_HOLD: if (w_zero) begin
                w_load = 1'b1;
`ifdef LCD_INIT_SEQ_EN
                if (r_init) begin
                    w_state_nx = ST_WAIT;
                    w_load_val = w_init_wait;
                end else
`endif
                if (!r_lower) begin
                    w_lower_nx = 1'b1;
                    if (NIBBLE_GAP_CYCLES > 0) begin
                        w_state_nx = ST_GAP;
                        w_load_val = L_GAP;
                    end else begin
                        w_state_nx = ST_SETUP;
                        w_load_val = L_SETUP;
                    end
                end else begin
                    w_state_nx = ST_WAIT;
                    w_load_val = is_long_cmd(r_rs, r_byte) ? L_LONG : L_CMD;
                end
            end
            ST_GAP: if (w_zero) begin
                w_state_nx = ST_SETUP;
                w_load     = 1'b1;
                w_load_val = L_SETUP;
            end
            ST_WAIT: if (w_zero) begin
                w_state_nx = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
                if (r_init && r_idx != 2'd3) begin
                    w_state_nx = ST_INIT_NIB;
                    w_idx_nx   = r_idx + 2'd1;
                end else begin
                    w_init_nx  = 1'b0;
                end
`endif
            end
`ifdef LCD_INIT_SEQ_EN
            ST_PWR_WAIT: if (w_zero) w_state_nx = ST_INIT_NIB;
            ST_INIT_NIB: begin
                // Init nibble rides in the high half so the normal path emits it
                w_state_nx = ST_SETUP;
                w_byte_nx  = {init_nibble(r_idx), 4'h0};
                w_rs_nx    = 1'b0;
                w_lower_nx = 1'b0;
                w_load     = 1'b1;
                w_load_val = L_SETUP;
            end
`endif
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the pins are plain registers
    always_comb begin
        w_ready_nx = (w_state_nx == ST_IDLE);
        w_e_nx     = (w_state_nx == ST_PULSE);
        w_rs_o_nx  = r_rs_o;
        w_data_nx  = r_data;
        case (w_state_nx)
            ST_IDLE: begin
                w_data_nx = 4'h0;
                w_rs_o_nx = 1'b0;
            end
            ST_SETUP, ST_PULSE, ST_HOLD: begin
                w_data_nx = w_lower_nx ? w_byte_nx[3:0] : w_byte_nx[7:4];
                w_rs_o_nx = w_rs_nx;
            end
            default: ;  // GAP/WAIT/power-up keep the last nibble on the bus
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_e     <= 1'b0;
            r_rs_o  <= 1'b0;
            r_data  <= 4'h0;
            r_ready <= RDY_RST;
            r_busy  <= ~RDY_RST;
        end else begin
            r_e     <= w_e_nx;
            r_rs_o  <= w_rs_o_nx;
            r_data  <= w_data_nx;
            r_ready <= w_ready_nx;
            r_busy  <= ~w_ready_nx;
        end
    end

    assign oReady                  = r_ready;
    assign oBusy                   = r_busy;
    assign oLCD_Enabled            = r_e;
    assign oLCD_RegisterSelect     = r_rs_o;
    assign oLCD_Data               = r_data;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;
endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer with small timing parameters. A timeline model
// derived from the nibble/delay rules predicts E, data, RS and ready for
// every cycle after acceptance. Define LCD_INIT_SEQ_EN to also check init.
module tb_lcd_nibble_writer;
    localparam int S = 2, EN = 3, H = 1, G = 4, CW = 6, LW = 20, PU = 10;
`ifdef LCD_INIT_SEQ_EN
    localparam bit RDY_RST = 1'b0;
`else
    localparam bit RDY_RST = 1'b1;
`endif

    logic       Clock = 1'b0, Reset = 1'b1, iValid = 1'b0, iRS = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oReady, oBusy, oLCD_Enabled, oLCD_RegisterSelect;
    logic       oLCD_StrataFlashControl, oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    int errors = 0, checks = 0;

    always #5 Clock = ~Clock;

    lcd_nibble_writer #(
        .SETUP_CYCLES(S), .ENABLE_CYCLES(EN), .HOLD_CYCLES(H),
        .NIBBLE_GAP_CYCLES(G), .CMD_WAIT_CYCLES(CW), .LONG_WAIT_CYCLES(LW),
        .POWERUP_CYCLES(PU), .CNT_W(20)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iValid(iValid), .iRS(iRS), .iData(iData),
        .oReady(oReady), .oBusy(oBusy), .oLCD_Enabled(oLCD_Enabled),
        .oLCD_RegisterSelect(oLCD_RegisterSelect),
        .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
        .oLCD_ReadWrite(oLCD_ReadWrite), .oLCD_Data(oLCD_Data)
    );

    function automatic int occ_of(input bit rs, input logic [7:0] d);
        return 2 * (S + EN + H) + G + ((!rs && d >= 8'h01 && d <= 8'h03) ? LW : CW);
    endfunction

    // Expected pins j edges after the acceptance edge (j = 0: first SETUP cycle)
    function automatic void model(input bit rs, input logic [7:0] d, input int j,
                                  output bit e, output bit rdy, output logic [3:0] dat,
                                  output bit dchk, output bit rschk);
        int nib, k;
        nib = S + EN + H;
        e = 0; rdy = 0; dat = 4'h0; dchk = 0; rschk = 0;
        if (j >= occ_of(rs, d)) begin
            rdy = 1; dchk = 1;
        end else if (j < nib) begin
            dat = d[7:4]; dchk = 1; rschk = 1; e = (j >= S && j < S + EN);
        end else if (j < nib + G) begin
            dat = d[7:4]; dchk = 1;
        end else if (j < 2 * nib + G) begin
            k = j - nib - G;
            dat = d[3:0]; dchk = 1; rschk = 1; e = (k >= S && k < S + EN);
        end
    endfunction

    // Called at a negedge with inputs already driven; returns just after the
    // accepting posedge.
    task automatic wait_accept(output bit ok);
        ok = 0;
        for (int n = 0; n < 3000; n++) begin
            if (oReady === 1'b1) begin
                @(posedge Clock);
                ok = 1;
                return;
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        bit ok;
        #12;
        checks++;
        if ({oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oLCD_StrataFlashControl,
             oLCD_ReadWrite, oReady, oBusy} !== {1'b0, 1'b0, 4'h0, 1'b1, 1'b0, RDY_RST, ~RDY_RST})
            begin errors++; $display("FAIL reset_init: E=%b RS=%b D=%h SF=%b RW=%b RDY=%b BSY=%b",
                oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oLCD_StrataFlashControl,
                oLCD_ReadWrite, oReady, oBusy); end
        @(negedge Clock); Reset = 0;
        iValid = 1; iRS = 1; iData = 8'hA5;
        wait_accept(ok);
        @(negedge Clock); iValid = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_accept: timeout"); end
        repeat (S) @(negedge Clock);
        checks++;
        if ({oLCD_Enabled, oLCD_Data} !== {1'b1, 4'hA}) begin
            errors++; $display("FAIL reset_prepulse: E=%b D=%h expected 1 a", oLCD_Enabled, oLCD_Data); end
        #2 Reset = 1;
        #1;
        checks++;
        if ({oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oLCD_StrataFlashControl,
             oLCD_ReadWrite, oReady, oBusy} !== {1'b0, 1'b0, 4'h0, 1'b1, 1'b0, RDY_RST, ~RDY_RST})
            begin errors++; $display("FAIL reset_async: E=%b RS=%b D=%h SF=%b RW=%b RDY=%b BSY=%b",
                oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oLCD_StrataFlashControl,
                oLCD_ReadWrite, oReady, oBusy); end
        #47;
        checks++;
        if ({oLCD_Enabled, oLCD_Data, oLCD_StrataFlashControl, oLCD_ReadWrite, oReady} !==
            {1'b0, 4'h0, 1'b1, 1'b0, RDY_RST})
            begin errors++; $display("FAIL reset_hold: E=%b D=%h SF=%b RW=%b RDY=%b",
                oLCD_Enabled, oLCD_Data, oLCD_StrataFlashControl, oLCD_ReadWrite, oReady); end
        @(negedge Clock); Reset = 0;
        @(negedge Clock);
        checks++;
        if (oReady !== RDY_RST) begin
            errors++; $display("FAIL reset_release: ready=%b expected %b", oReady, RDY_RST); end
    endtask

`ifdef LCD_INIT_SEQ_EN
    task automatic test_init();
        logic [3:0] nibs[$];
        bit         rs_bad, prev_e, done;
        int         n, min_n;
        logic [3:0] exp_nib [4];
        exp_nib[0] = 4'h3; exp_nib[1] = 4'h3; exp_nib[2] = 4'h3; exp_nib[3] = 4'h2;
        rs_bad = 0; prev_e = 0; done = 0; n = 0;
        min_n = PU + 4 * (S + EN + H) + (205000 + 5000 + 2000 + 2000) * CW / 2000 - 2;
        while (!done && n < 5000) begin
            if (oLCD_Enabled && !prev_e) begin
                nibs.push_back(oLCD_Data);
                if (oLCD_RegisterSelect !== 1'b0) rs_bad = 1;
            end
            prev_e = oLCD_Enabled;
            if (oReady === 1'b1) done = 1;
            else begin @(negedge Clock); n++; end
        end
        checks++;
        if (!done || n < min_n) begin
            errors++; $display("FAIL init_ready_time: got %0d cycles, need >= %0d", n, min_n); end
        checks++;
        if (nibs.size() != 4 || rs_bad) begin
            errors++; $display("FAIL init_count: nibbles=%0d rs_bad=%b expected 4 0", nibs.size(), rs_bad); end
        for (int i = 0; i < 4 && i < nibs.size(); i++) begin
            checks++;
            if (nibs[i] !== exp_nib[i]) begin
                errors++; $display("FAIL init_nib%0d: got %h expected %h", i, nibs[i], exp_nib[i]); end
        end
    endtask
`endif

    typedef struct { bit rs; logic [7:0] d; bit scr; } xfer_t;

    // Data write, long/short waits, input latching and random bytes.
    task automatic test_transfers();
        xfer_t      tbl[$];
        bit         ok, e, rdy, dchk, rschk, rs;
        logic [3:0] dat;
        logic [7:0] d;
        tbl.push_back('{1'b1, 8'h41, 1'b0});
        tbl.push_back('{1'b0, 8'h01, 1'b0});
        tbl.push_back('{1'b0, 8'h28, 1'b0});
        tbl.push_back('{1'b0, 8'h02, 1'b0});
        tbl.push_back('{1'b0, 8'h03, 1'b0});
        tbl.push_back('{1'b1, 8'h01, 1'b0});
        tbl.push_back('{1'b0, 8'h04, 1'b0});
        tbl.push_back('{1'b1, 8'hC3, 1'b1});
        tbl.push_back('{1'b0, 8'h02, 1'b1});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'($urandom_range(0, 1)),
                            ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                            1'($urandom_range(0, 1))});
        foreach (tbl[t]) begin
            rs = tbl[t].rs; d = tbl[t].d;
            iRS = rs; iData = d; iValid = 1;
            wait_accept(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL xfer_accept %h: timeout", d); iValid = 0; continue; end
            for (int j = 0; j <= occ_of(rs, d); j++) begin
                @(negedge Clock);
                if (j == 0) iValid = 0;
                if (tbl[t].scr) begin iData = 8'($urandom); iRS = 1'($urandom); end
                model(rs, d, j, e, rdy, dat, dchk, rschk);
                checks++;
                if ({oReady, oBusy, oLCD_Enabled} !== {rdy, ~rdy, e}) begin
                    errors++; $display("FAIL xfer_ctl %h j=%0d: rdy/bsy/E=%b%b%b expected %b%b%b",
                        d, j, oReady, oBusy, oLCD_Enabled, rdy, ~rdy, e); end
                if (dchk) begin
                    checks++;
                    if (oLCD_Data !== dat) begin
                        errors++; $display("FAIL xfer_data %h j=%0d: got %h expected %h", d, j, oLCD_Data, dat); end
                end
                if (rschk) begin
                    checks++;
                    if ({oLCD_RegisterSelect, oLCD_StrataFlashControl, oLCD_ReadWrite} !== {rs, 1'b1, 1'b0}) begin
                        errors++; $display("FAIL xfer_rs %h j=%0d: RS/SF/RW=%b%b%b expected %b10",
                            d, j, oLCD_RegisterSelect, oLCD_StrataFlashControl, oLCD_ReadWrite, rs); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit         ok, e, rdy, dchk, rschk;
        logic [3:0] dat;
        iRS = 1; iData = 8'h48; iValid = 1;
        wait_accept(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_accept: timeout"); iValid = 0; return; end
        for (int j = 0; j <= occ_of(1, 8'h48); j++) begin
            @(negedge Clock);
            if (j == 0) iData = 8'h49;
            model(1, 8'h48, j, e, rdy, dat, dchk, rschk);
            checks++;
            if ({oReady, oLCD_Enabled} !== {rdy, e} || (dchk && oLCD_Data !== dat)) begin
                errors++; $display("FAIL b2b_first j=%0d: rdy/E/D=%b%b%h expected %b%b%h",
                    j, oReady, oLCD_Enabled, oLCD_Data, rdy, e, dat); end
        end
        // Second byte is taken on the edge closing the single ready cycle
        for (int j = 0; j <= occ_of(1, 8'h49); j++) begin
            @(negedge Clock);
            if (j == 0) iValid = 0;
            model(1, 8'h49, j, e, rdy, dat, dchk, rschk);
            checks++;
            if ({oReady, oLCD_Enabled} !== {rdy, e} || (dchk && oLCD_Data !== dat) ||
                (rschk && oLCD_RegisterSelect !== 1'b1)) begin
                errors++; $display("FAIL b2b_second j=%0d: rdy/E/D/RS=%b%b%h%b expected %b%b%h1",
                    j, oReady, oLCD_Enabled, oLCD_Data, oLCD_RegisterSelect, rdy, e, dat); end
        end
    endtask

    initial begin
        test_reset();
`ifdef LCD_INIT_SEQ_EN
        test_init();
`endif
        test_transfers();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
